fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the integer pipeline; successor to the fixed two-stage, two-operand forwarding unit. Tracks every in-flight register write in an internal shift register of `FWD_DEPTH` entries, each with a result-ready countdown. For each of `NUM_SRC` source operands at the issue stage, it produces bypass-mux selects, or a stall when the producing instruction's result is not yet available. Sits beside the decode/issue stage and drives the operand bypass muxes and the issue stall.

## Interface
- `REG_LOGSIZE`, default 5: register index width; matches `` `regfile_logsize ``.
- `NUM_SRC`, default 2: number of source operands checked per issued instruction.
- `FWD_DEPTH`, default 2: number of downstream stages that can forward; entry k is the instruction issued k+1 cycles earlier.
- `SEL_W`, default `$clog2(FWD_DEPTH+1)`: select width (derived; do not override).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_valid`  in  1  issue slot holds a real instruction.
- `id_regwrite`  in  1  issuing instruction writes `id_rd`.
- `id_rd`  in  `REG_LOGSIZE`  destination of the issuing instruction.
- `id_lat`  in  `SEL_W`  extra stages before the result is forwardable: 0 for ALU, 1 for load, and so on.
- `id_src`  in  `NUM_SRC*REG_LOGSIZE`  packed source register indices; operand i is `[i*REG_LOGSIZE +: REG_LOGSIZE]`.
- `flush`  in  1  kill the instruction at issue; it is inserted as a bubble.
- `hold`  in  1  global pipeline freeze; tracking state does not advance.
- `sel`  out  `NUM_SRC*SEL_W`  per-operand mux select: 0 = register file, k = entry k-1.
- `stall`  out  1  issue must not advance this cycle.

## Operation
- **Entry fields:** `valid`, `rd`, `cnt` (`SEL_W` bits).
- **Select logic:** combinational from the current entries and `id_src`.
  - src == 0: `sel` = 0, and this operand never stalls.
  - Otherwise, find the lowest-index (youngest) entry with `valid && rd == src`.
  - If none matches, `sel` = 0.
  - If the match has `cnt == 0`, `sel` = index+1.
  - If the match has `cnt != 0`, the operand is unready and `sel` = 0.
  - An older matching entry is never used when a younger one matches.
- **Stall:** `stall` = `id_valid && !flush &&` (any operand unready). Unused operands are driven to 0 by decode.
- **Update on each rising edge when `hold` = 0:**
  - Entries shift: entry k moves to k+1, and entry `FWD_DEPTH-1` is discarded (its write has reached the register file).
  - Each surviving `cnt` decrements, saturating at 0.
  - Entry 0 loads `{1, id_rd, min(id_lat, FWD_DEPTH-1)}` when `id_valid && id_regwrite && id_rd != 0 && !stall && !flush`. Otherwise entry 0 loads a bubble (`valid` = 0).
- **`hold` = 1:** all entries keep their value; `sel` and `stall` continue to be evaluated from the frozen state.
- **Simultaneous events:**
  - `hold` has priority over everything.
  - `flush` has priority over `stall` (the bubble is inserted and `stall` = 0).

## Timing
- **Reset** (`rst_n` low, asynchronous): all entries `valid` = 0, `cnt` = 0. Hence `sel` = 0 and `stall` = 0 during and immediately after reset.
- **Reset mid-operation:** all tracking is discarded; no stale forwarding after release.
- **Latency:** `sel`/`stall` are zero-cycle (same cycle as `id_src`). An issued instruction becomes visible at entry 0 one cycle later.
- **ALU result** (`id_lat` = 0): forwardable to the next instruction with `sel` = 1, and to the one after with `sel` = 2.
- **Load** (`id_lat` = 1) followed by a dependent instruction:
  - Exactly one stall cycle.
  - The dependent then issues with `sel` = 2: the load has moved to entry 1 with `cnt` = 0.
- **Stall handshake:** while `stall` = 1, upstream holds the issue slot unchanged. The block keeps advancing older entries, so the stall resolves without external help after at most `FWD_DEPTH-1` cycles.

## Configuration
- **`FWD_PERF_CNT_EN` defined:** adds outputs `perf_stall_cnt` and `perf_fwd_cnt` (32 bits each, reset to 0, wrapping at 2^32).
  - `perf_stall_cnt` counts cycles with `stall` = 1 and `hold` = 0.
  - `perf_fwd_cnt` counts accepted issues (`id_valid && !stall && !flush && !hold`) with any `sel` != 0.
- **Undefined:** the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset held with random inputs: `sel` = 0 and `stall` = 0. After release, issue `add x5`, then `sub` reading x5 → `sel[0]` = 1, `stall` = 0.
- Load to x7 (`id_lat` = 1), next instruction reads x7 on operand 1:
  - Cycle 1: `stall` = 1.
  - Cycle 2: `stall` = 0, `sel[1]` = 2.
- Two in-flight writes to x3 (entries 0 and 1, both `cnt` = 0) → `sel` = 1 (youngest wins). Reading x0 with an x0 write attempt → `sel` = 0, no stall.
- Load to x9 followed by a dependent with `hold` = 1 for 3 cycles → `stall` stays 1 and entries are frozen. After `hold` drops, `stall` = 1 for one more cycle, then `sel` = 2.
- `flush` during a load-use stall → `stall` = 0 and a bubble enters entry 0. Next cycle, an instruction reading the flushed rd gets `sel` = 0.
- With `FWD_DEPTH` = 4 and `id_lat` = 3 on x12: the dependent stalls 3 cycles, then `sel` = 4. Under `FWD_PERF_CNT_EN`, `perf_stall_cnt` = 3 and `perf_fwd_cnt` = 1.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall generation.
// Tracks in-flight register writes in a FWD_DEPTH-entry shift register, each
// entry carrying a countdown until its result can be forwarded.
// Optional build macro: FWD_PERF_CNT_EN adds stall / forward event counters.
module fwd_hazard_unit #(
   parameter int unsigned REG_LOGSIZE = 5,
   parameter int unsigned NUM_SRC     = 2,
   parameter int unsigned FWD_DEPTH   = 2,
   parameter int unsigned SEL_W       = $clog2(FWD_DEPTH + 1)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           id_valid,
   input  logic                           id_regwrite,
   input  logic [REG_LOGSIZE-1:0]         id_rd,
   input  logic [SEL_W-1:0]               id_lat,
   input  logic [NUM_SRC*REG_LOGSIZE-1:0] id_src,
   input  logic                           flush,
   input  logic                           hold,
`ifdef FWD_PERF_CNT_EN
   output logic [31:0]                    perf_stall_cnt,
   output logic [31:0]                    perf_fwd_cnt,
`endif
   output logic [NUM_SRC*SEL_W-1:0]       sel,
   output logic                           stall
);

   logic                   ent_valid [FWD_DEPTH];
   logic [REG_LOGSIZE-1:0] ent_rd    [FWD_DEPTH];
   logic [SEL_W-1:0]       ent_cnt   [FWD_DEPTH];

   logic [NUM_SRC-1:0]     unready;
   logic [REG_LOGSIZE-1:0] src;
   logic                   found;
   logic                   push;
   logic [SEL_W-1:0]       lat_clip;

   // Per-operand select: youngest matching entry wins; unready match forces sel 0
   always_comb begin
      sel     = '0;
      unready = '0;
      src     = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         src   = id_src[i*REG_LOGSIZE +: REG_LOGSIZE];
         found = 1'b0;
         if (src != '0) begin
            for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
               if (!found && ent_valid[k] && (ent_rd[k] == src)) begin
                  found = 1'b1;
                  if (ent_cnt[k] == '0)
                     sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                  else
                     unready[i] = 1'b1;
               end
            end
         end
      end
   end

   // Stall and entry-0 load qualification; flush overrides stall
   always_comb begin
      stall    = id_valid && !flush && (|unready);
      push     = id_valid && id_regwrite && (id_rd != '0) && !stall && !flush;
      lat_clip = (id_lat > SEL_W'(FWD_DEPTH - 1)) ? SEL_W'(FWD_DEPTH - 1) : id_lat;
   end

   // Tracking shift register: shift and count down unless frozen by hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
            ent_valid[k] <= 1'b0;
            ent_rd[k]    <= '0;
            ent_cnt[k]   <= '0;
         end
      end else if (!hold) begin
         for (int unsigned k = 1; k < FWD_DEPTH; k++) begin
            ent_valid[k] <= ent_valid[k-1];
            ent_rd[k]    <= ent_rd[k-1];
            ent_cnt[k]   <= (ent_cnt[k-1] != '0) ? ent_cnt[k-1] - SEL_W'(1) : '0;
         end
         ent_valid[0] <= push;
         ent_rd[0]    <= push ? id_rd : '0;
         ent_cnt[0]   <= push ? lat_clip : '0;
      end
   end

`ifdef FWD_PERF_CNT_EN
   // Event counters: stalled cycles and accepted issues that used a bypass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_fwd_cnt   <= '0;
      end else if (!hold) begin
         if (stall)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (id_valid && !stall && !flush && (sel != '0))
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding selects and stalls on a
// default-sized instance and a FWD_DEPTH=4 instance.
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   logic rst_n;

   // default instance (FWD_DEPTH=2, SEL_W=2)
   logic       a_valid, a_wr, a_flush, a_hold;
   logic [4:0] a_rd;
   logic [1:0] a_lat;
   logic [9:0] a_src;
   logic [3:0] a_sel;
   logic       a_stall;

   // deep instance (FWD_DEPTH=4, SEL_W=3)
   logic       b_valid, b_wr, b_flush, b_hold;
   logic [4:0] b_rd;
   logic [2:0] b_lat;
   logic [9:0] b_src;
   logic [5:0] b_sel;
   logic       b_stall;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] a_pstall, a_pfwd, b_pstall, b_pfwd;
`endif

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit u_dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(a_valid), .id_regwrite(a_wr), .id_rd(a_rd), .id_lat(a_lat),
      .id_src(a_src), .flush(a_flush), .hold(a_hold),
`ifdef FWD_PERF_CNT_EN
      .perf_stall_cnt(a_pstall), .perf_fwd_cnt(a_pfwd),
`endif
      .sel(a_sel), .stall(a_stall)
   );

   fwd_hazard_unit #(.FWD_DEPTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .id_valid(b_valid), .id_regwrite(b_wr), .id_rd(b_rd), .id_lat(b_lat),
      .id_src(b_src), .flush(b_flush), .hold(b_hold),
`ifdef FWD_PERF_CNT_EN
      .perf_stall_cnt(b_pstall), .perf_fwd_cnt(b_pfwd),
`endif
      .sel(b_sel), .stall(b_stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // drive default instance inputs, then settle before sampling
   task automatic drv_a(input logic v, input logic w, input logic [4:0] rd,
                        input logic [1:0] lat, input logic [4:0] s0,
                        input logic [4:0] s1, input logic fl, input logic hd);
      a_valid = v; a_wr = w; a_rd = rd; a_lat = lat;
      a_src = {s1, s0}; a_flush = fl; a_hold = hd;
      #1;
   endtask

   task automatic drv_b(input logic v, input logic w, input logic [4:0] rd,
                        input logic [2:0] lat, input logic [4:0] s0,
                        input logic [4:0] s1);
      b_valid = v; b_wr = w; b_rd = rd; b_lat = lat;
      b_src = {s1, s0}; b_flush = 1'b0; b_hold = 1'b0;
      #1;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drv_b(1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 5'd0);

      // reset held with random stimulus
      for (int i = 0; i < 3; i++) begin
         drv_a(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
               5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
         check("rst_sel", 32'(a_sel), 32'd0);
         check("rst_stall", 32'(a_stall), 32'd0);
         cyc();
      end
      rst_n = 1'b1;

      // ALU forwarding: add x5, sub reads x5, then a reader of x5 and x6
      drv_a(1, 1, 5'd5, 2'd0, 5'd1, 5'd2, 0, 0);
      check("post_rst_sel", 32'(a_sel), 32'd0);
      check("post_rst_stall", 32'(a_stall), 32'd0);
      cyc();
      drv_a(1, 1, 5'd6, 2'd0, 5'd5, 5'd0, 0, 0);
      check("alu_next_sel", 32'(a_sel), 32'h1);
      check("alu_next_stall", 32'(a_stall), 32'd0);
      cyc();
      drv_a(1, 0, 5'd0, 2'd0, 5'd5, 5'd6, 0, 0);
      check("alu_two_sel", 32'(a_sel), 32'h6);
      cyc();

      // load x7 then dependent on operand 1
      drv_a(1, 1, 5'd7, 2'd1, 5'd0, 5'd0, 0, 0);
      check("ld_issue_stall", 32'(a_stall), 32'd0);
      cyc();
      drv_a(1, 1, 5'd8, 2'd0, 5'd0, 5'd7, 0, 0);
      check("ld_use_stall1", 32'(a_stall), 32'd1);
      check("ld_use_sel1", 32'(a_sel), 32'd0);
      cyc();
      drv_a(1, 1, 5'd8, 2'd0, 5'd0, 5'd7, 0, 0);
      check("ld_use_stall2", 32'(a_stall), 32'd0);
      check("ld_use_sel2", 32'(a_sel), 32'h8);
      cyc();

      // two writes to x3: youngest wins
      drv_a(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 0, 0);
      cyc();
      drv_a(1, 1, 5'd3, 2'd0, 5'd0, 5'd0, 0, 0);
      cyc();
      drv_a(1, 1, 5'd0, 2'd0, 5'd3, 5'd0, 0, 0);
      check("youngest_sel", 32'(a_sel), 32'h1);
      check("youngest_stall", 32'(a_stall), 32'd0);
      cyc();
      drv_a(1, 1, 5'd0, 2'd0, 5'd0, 5'd3, 0, 0);
      check("x0_write_sel", 32'(a_sel), 32'h8);
      check("x0_write_stall", 32'(a_stall), 32'd0);
      cyc();

      // load x9, dependent frozen by hold for 3 cycles
      drv_a(1, 1, 5'd9, 2'd1, 5'd0, 5'd0, 0, 0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         drv_a(1, 1, 5'd10, 2'd0, 5'd9, 5'd0, 0, 1);
         check("hold_stall", 32'(a_stall), 32'd1);
         cyc();
      end
      drv_a(1, 1, 5'd10, 2'd0, 5'd9, 5'd0, 0, 0);
      check("hold_release_stall", 32'(a_stall), 32'd1);
      cyc();
      drv_a(1, 1, 5'd10, 2'd0, 5'd9, 5'd0, 0, 0);
      check("hold_after_stall", 32'(a_stall), 32'd0);
      check("hold_after_sel", 32'(a_sel), 32'h2);
      cyc();

      // flush during a load-use stall
      drv_a(1, 1, 5'd11, 2'd1, 5'd0, 5'd0, 0, 0);
      cyc();
      drv_a(1, 1, 5'd12, 2'd0, 5'd11, 5'd0, 0, 0);
      check("flush_pre_stall", 32'(a_stall), 32'd1);
      drv_a(1, 1, 5'd12, 2'd0, 5'd11, 5'd0, 1, 0);
      check("flush_stall", 32'(a_stall), 32'd0);
      cyc();
      drv_a(1, 0, 5'd0, 2'd0, 5'd12, 5'd11, 0, 0);
      check("flushed_rd_sel", 32'(a_sel), 32'h8);
      cyc();

      // latency above depth is clipped: single stall on FWD_DEPTH=2
      drv_a(1, 1, 5'd14, 2'd3, 5'd0, 5'd0, 0, 0);
      cyc();
      drv_a(1, 0, 5'd0, 2'd0, 5'd14, 5'd0, 0, 0);
      check("clip_stall1", 32'(a_stall), 32'd1);
      cyc();
      drv_a(1, 0, 5'd0, 2'd0, 5'd14, 5'd0, 0, 0);
      check("clip_stall2", 32'(a_stall), 32'd0);
      check("clip_sel", 32'(a_sel), 32'h2);
      cyc();

      // deep instance: x12 with 3 extra stages
      drv_b(1, 1, 5'd12, 3'd3, 5'd0, 5'd0);
      check("d4_issue_stall", 32'(b_stall), 32'd0);
      cyc();
      for (int i = 0; i < 3; i++) begin
         drv_b(1, 1, 5'd13, 3'd0, 5'd12, 5'd0);
         check("d4_stall", 32'(b_stall), 32'd1);
         check("d4_stall_sel", 32'(b_sel), 32'd0);
         cyc();
      end
      drv_b(1, 1, 5'd13, 3'd0, 5'd12, 5'd0);
      check("d4_go_stall", 32'(b_stall), 32'd0);
      check("d4_go_sel", 32'(b_sel), 32'd4);
      cyc();
      drv_b(0, 0, 5'd0, 3'd0, 5'd0, 5'd0);
`ifdef FWD_PERF_CNT_EN
      check("d4_perf_stall", b_pstall, 32'd3);
      check("d4_perf_fwd", b_pfwd, 32'd1);
`endif

      // reset mid-operation discards tracking
      drv_a(1, 1, 5'd13, 2'd0, 5'd0, 5'd0, 0, 0);
      cyc();
      drv_a(1, 0, 5'd0, 2'd0, 5'd13, 5'd0, 0, 0);
      check("pre_midrst_sel", 32'(a_sel), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_sel", 32'(a_sel), 32'd0);
      cyc();
      rst_n = 1'b1;
      drv_a(1, 0, 5'd0, 2'd0, 5'd13, 5'd0, 0, 0);
      check("after_midrst_sel", 32'(a_sel), 32'd0);
      check("after_midrst_stall", 32'(a_stall), 32'd0);
      drv_b(1, 0, 5'd0, 3'd0, 5'd13, 5'd12);
      check("d4_after_midrst_sel", 32'(b_sel), 32'd0);
`ifdef FWD_PERF_CNT_EN
      check("d4_perf_rst", b_pstall, 32'd0);
`endif
      cyc();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
